// File: rtl/poly_eval_pkg.sv
// Shared encodings for the polynomial-evaluation invoke controller.
// Optional watchdog is enabled with the POLY_WATCHDOG_EN macro (see top level).
package poly_eval_pkg;

   // Firing modes presented to the level-2 FSM
   typedef enum logic [2:0] {
      ModeGetCommand = 3'd0,
      ModeStp        = 3'd1,
      ModeEvp        = 3'd2,
      ModeEvb        = 3'd3,
      ModeOutput     = 3'd4,
      ModeRst        = 3'd5,
      ModeNone       = 3'd7
   } mode_e;

   // Opcodes delivered by the get_command level-3 FSM
   localparam logic [7:0] OpStp = 8'h01;
   localparam logic [7:0] OpEvp = 8'h02;
   localparam logic [7:0] OpEvb = 8'h03;
   localparam logic [7:0] OpRst = 8'h04;

   // Controller states
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StCheck  = 3'd1,
      StStart  = 3'd2,
      StWait   = 3'd3,
      StUpdate = 3'd4
   } state_e;

   // Width of a population / free-space port for a FIFO of the given depth
   function automatic int unsigned calc_pw(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/poly_eval_invoke_fsm1_enable_check.sv
// Combinational firing-enable test: does the FIFO state satisfy the pending mode?
module poly_enable_check
   import poly_eval_pkg::*;
#(
   parameter int unsigned PW = 11
) (
   input  mode_e           mode,
   input  logic [PW-1:0]   pop_in_command,
   input  logic [PW-1:0]   pop_in_data,
   input  logic [PW-1:0]   free_out_result,
   input  logic [PW-1:0]   free_out_status,
   input  logic [4:0]      arg_n,
   output logic            enabled
);

   // N+1 in 6 bits so N=31 demands 32 tokens without wrapping
   logic [5:0] need_stp;
   assign need_stp = {1'b0, arg_n} + 6'd1;

   // Decode the token/space requirement of each mode
   always_comb begin
      enabled = 1'b0;
      unique case (mode)
         ModeGetCommand: enabled = (pop_in_command >= PW'(1));
         ModeStp:        enabled = (pop_in_data >= PW'(need_stp));
         ModeEvp:        enabled = (pop_in_data >= PW'(1));
         ModeEvb:        enabled = (pop_in_data >= PW'(2));
         ModeRst:        enabled = 1'b1;
         ModeOutput:     enabled = (free_out_result >= PW'(1)) && (free_out_status >= PW'(1));
         default:        enabled = 1'b0;
      endcase
   end

endmodule

// File: rtl/poly_eval_invoke_fsm1.sv
// Level-1 CFDF invoke controller for the polynomial-evaluation actor.
// Sequence: GET_COMMAND -> {STP|EVP|EVB|RST} -> OUTPUT -> GET_COMMAND.
// Define POLY_WATCHDOG_EN to add a WAIT-state watchdog that sets wdog_err.
module poly_eval_invoke_fsm1
   import poly_eval_pkg::*;
#(
   parameter int unsigned word_size   = 16,
   parameter int unsigned buffer_size = 1024,
   parameter int unsigned WDOG_CYCLES = 4096,
   localparam int unsigned PW = calc_pw(buffer_size)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          invoke,
   input  logic [PW-1:0] pop_in_command,
   input  logic [PW-1:0] pop_in_data,
   input  logic [PW-1:0] free_out_result,
   input  logic [PW-1:0] free_out_status,
   input  logic [7:0]    instr_in,
   input  logic [4:0]    arg2_in,
   input  logic [1:0]    error_in,
   input  logic          done_fsm2,
   output logic          start_fsm2,
   output logic [2:0]    next_mode_out,
   output logic          busy,
   output logic          wdog_err
);

   // word_size only mirrors FSM2; reject nonsense configurations at elaboration
   if (word_size == 0) begin : g_bad_word_size
      $error("word_size must be nonzero");
   end
   if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65536) begin : g_bad_wdog
      $error("WDOG_CYCLES must be in 2..65536");
   end

   state_e     state_q;
   mode_e      mode_q;
   mode_e      upd_mode;
   logic [7:0] instr_q;
   logic [4:0] arg_n_q;
   logic [1:0] err_q;
   logic       enabled;

`ifdef POLY_WATCHDOG_EN
   logic [15:0] wdog_cnt_q;
   logic        wdog_hit_q;
`else
   assign wdog_err = 1'b0;
`endif

   poly_enable_check #(
      .PW (PW)
   ) u_enable_check (
      .mode            (mode_q),
      .pop_in_command  (pop_in_command),
      .pop_in_data     (pop_in_data),
      .free_out_result (free_out_result),
      .free_out_status (free_out_status),
      .arg_n           (arg_n_q),
      .enabled         (enabled)
   );

   // Next firing mode, derived from the mode just completed and the captured command
   always_comb begin
      upd_mode = ModeOutput;
      unique case (mode_q)
         ModeGetCommand: begin
            if (err_q != 2'd0) begin
               upd_mode = ModeOutput;
            end else begin
               case (instr_q)
                  OpStp:   upd_mode = ModeStp;
                  OpEvp:   upd_mode = ModeEvp;
                  OpEvb:   upd_mode = ModeEvb;
                  OpRst:   upd_mode = ModeRst;
                  default: upd_mode = ModeOutput;
               endcase
            end
         end
         ModeOutput: upd_mode = ModeGetCommand;
         default:    upd_mode = ModeOutput;
      endcase
`ifdef POLY_WATCHDOG_EN
      // A timed-out firing restarts the command sequence
      if (wdog_hit_q) upd_mode = ModeGetCommand;
`endif
   end

   // Controller state machine with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         mode_q        <= ModeGetCommand;
         instr_q       <= 8'd0;
         arg_n_q       <= 5'd0;
         err_q         <= 2'd0;
         start_fsm2    <= 1'b0;
         next_mode_out <= ModeNone;
         busy          <= 1'b0;
`ifdef POLY_WATCHDOG_EN
         wdog_cnt_q    <= 16'd0;
         wdog_hit_q    <= 1'b0;
         wdog_err      <= 1'b0;
`endif
      end else begin
         start_fsm2 <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (invoke) state_q <= StCheck;
            end
            StCheck: begin
               // Enable wins over invoke: invoke only parks when the firing is blocked
               if (enabled) begin
                  state_q       <= StStart;
                  start_fsm2    <= 1'b1;
                  next_mode_out <= mode_q;
                  busy          <= 1'b1;
               end else if (!invoke) begin
                  state_q <= StIdle;
               end
            end
            StStart: begin
               // done_fsm2 is deliberately not looked at here
               state_q <= StWait;
`ifdef POLY_WATCHDOG_EN
               wdog_cnt_q <= 16'd0;
`endif
            end
            StWait: begin
               if (done_fsm2) begin
                  state_q <= StUpdate;
                  if (mode_q == ModeGetCommand) begin
                     instr_q <= instr_in;
                     arg_n_q <= arg2_in;
                     err_q   <= error_in;
                  end
`ifdef POLY_WATCHDOG_EN
               end else if (wdog_cnt_q == 16'(WDOG_CYCLES - 1)) begin
                  state_q    <= StUpdate;
                  wdog_hit_q <= 1'b1;
                  wdog_err   <= 1'b1;
               end else begin
                  wdog_cnt_q <= wdog_cnt_q + 16'd1;
`endif
               end
            end
            StUpdate: begin
               state_q       <= StCheck;
               mode_q        <= upd_mode;
               next_mode_out <= ModeNone;
               busy          <= 1'b0;
`ifdef POLY_WATCHDOG_EN
               wdog_hit_q    <= 1'b0;
`endif
            end
            default: begin
               state_q       <= StIdle;
               next_mode_out <= ModeNone;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poly_eval_invoke_fsm1.sv
// Scoreboard bench for poly_eval_invoke_fsm1: expected modes are queued before
// each firing is enabled and compared when start_fsm2 pulses.
module tb_poly_eval_invoke_fsm1;

   localparam int PW = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          invoke;
   logic [PW-1:0] pop_in_command;
   logic [PW-1:0] pop_in_data;
   logic [PW-1:0] free_out_result;
   logic [PW-1:0] free_out_status;
   logic [7:0]    instr_in;
   logic [4:0]    arg2_in;
   logic [1:0]    error_in;
   logic          done_fsm2;
   logic          start_fsm2;
   logic [2:0]    next_mode_out;
   logic          busy;
   logic          wdog_err;

   int n_checks = 0;
   int n_errors = 0;
   logic [2:0] exp_q[$];

   poly_eval_invoke_fsm1 #(
      .word_size   (16),
      .buffer_size (1024),
      .WDOG_CYCLES (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .invoke          (invoke),
      .pop_in_command  (pop_in_command),
      .pop_in_data     (pop_in_data),
      .free_out_result (free_out_result),
      .free_out_status (free_out_status),
      .instr_in        (instr_in),
      .arg2_in         (arg2_in),
      .error_in        (error_in),
      .done_fsm2       (done_fsm2),
      .start_fsm2      (start_fsm2),
      .next_mode_out   (next_mode_out),
      .busy            (busy),
      .wdog_err        (wdog_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard: every start pulse must match the oldest queued mode
   always @(negedge clk) begin
      if (start_fsm2 === 1'b1) begin
         check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check_eq("start_mode", 32'(next_mode_out), 32'(exp_q.pop_front()));
            check_eq("start_busy", 32'(busy), 32'd1);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait for a start pulse; returns the number of negedges waited
   task automatic wait_start(input string tag, output int waited);
      waited = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         waited++;
         if (start_fsm2 === 1'b1) return;
      end
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Called at a negedge in WAIT; returns at the negedge in UPDATE
   task automatic do_done();
      done_fsm2 = 1'b1;
      @(negedge clk);
      done_fsm2 = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_start"}, 32'(start_fsm2), 32'd0);
      check_eq({tag, "_mode"}, 32'(next_mode_out), 32'd7);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int w;
      rst = 1'b1; invoke = 1'b0; done_fsm2 = 1'b0;
      pop_in_command = '0; pop_in_data = '0;
      free_out_result = 11'd5; free_out_status = 11'd5;
      instr_in = 8'd0; arg2_in = 5'd0; error_in = 2'd0;
      tick(3);
      check_idle_outputs("reset");
      check_eq("reset_wdog", 32'(wdog_err), 32'd0);

      // No command tokens: held in CHECK
      rst = 1'b0; invoke = 1'b1;
      tick(6);
      check_idle_outputs("gc_blocked");

      // One command token -> GET_COMMAND fires the following cycle
      exp_q.push_back(3'd0);
      pop_in_command = 11'd1;
      wait_start("gc1", w);
      check_eq("gc1_latency", 32'(w), 32'd1);

      // STP N=3 with only 3 data tokens: blocked
      instr_in = 8'h01; arg2_in = 5'd3;
      tick(1);
      do_done();
      pop_in_data = 11'd3;
      tick(6);
      check_idle_outputs("stp_blocked");

      exp_q.push_back(3'd1);
      pop_in_data = 11'd4;
      wait_start("stp", w);
      check_eq("stp_latency", 32'(w), 32'd1);
      tick(1);
      check_eq("hold_wait_mode", 32'(next_mode_out), 32'd1);
      pop_in_data = 11'd0;  // back-pressure while waiting
      tick(2);
      check_eq("bp_busy", 32'(busy), 32'd1);
      check_eq("bp_mode", 32'(next_mode_out), 32'd1);
      do_done();
      check_eq("hold_update_mode", 32'(next_mode_out), 32'd1);
      check_eq("hold_update_busy", 32'(busy), 32'd1);

      exp_q.push_back(3'd4);
      wait_start("out1", w);
      tick(1);
      do_done();
      exp_q.push_back(3'd0);
      wait_start("gc2", w);

      // Error code on the command forces OUTPUT; blocked on status space
      instr_in = 8'h01; error_in = 2'b01; free_out_status = 11'd0;
      tick(1);
      do_done();
      error_in = 2'd0;
      tick(6);
      check_idle_outputs("out_blocked");
      exp_q.push_back(3'd4);
      free_out_status = 11'd1;
      wait_start("err_out", w);
      tick(1);
      do_done();
      exp_q.push_back(3'd0);
      wait_start("gc3", w);

      // Unknown opcode -> OUTPUT
      instr_in = 8'h09;
      exp_q.push_back(3'd4);
      tick(1);
      do_done();
      wait_start("badop_out", w);
      tick(1);
      do_done();
      exp_q.push_back(3'd0);
      wait_start("gc4", w);

      // EVB needs two data tokens; also an early done in START is ignored
      instr_in = 8'h03; pop_in_data = 11'd1;
      tick(1);
      do_done();
      tick(6);
      check_idle_outputs("evb_blocked");
      exp_q.push_back(3'd3);
      pop_in_data = 11'd2;
      wait_start("evb", w);
      done_fsm2 = 1'b1;
      tick(1);
      done_fsm2 = 1'b0;
      tick(2);
      check_eq("early_done_busy", 32'(busy), 32'd1);
      check_eq("early_done_mode", 32'(next_mode_out), 32'd3);
      do_done();
      exp_q.push_back(3'd4);
      wait_start("evb_out", w);
      tick(1);
      do_done();
      exp_q.push_back(3'd0);
      wait_start("gc5", w);

      // Reset during EVP WAIT returns to IDLE with mode GET_COMMAND
      instr_in = 8'h02; pop_in_data = 11'd1;
      exp_q.push_back(3'd2);
      tick(1);
      do_done();
      wait_start("evp", w);
      tick(1);
      rst = 1'b1;
      tick(1);
      check_idle_outputs("rst_mid");
      check_eq("rst_mid_wdog", 32'(wdog_err), 32'd0);
      rst = 1'b0;
      exp_q.push_back(3'd0);
      wait_start("gc_after_rst", w);
      check_eq("gc_after_rst_latency", 32'(w), 32'd2);

      // STP N=31 needs 32 tokens; invoke drop parks while blocked
      instr_in = 8'h01; arg2_in = 5'd31; pop_in_data = 11'd31;
      tick(1);
      do_done();
      tick(3);
      invoke = 1'b0;
      tick(4);
      check_idle_outputs("n31_blocked");
      pop_in_data = 11'd32;
      tick(4);
      check_idle_outputs("parked_idle");
      exp_q.push_back(3'd1);
      invoke = 1'b1;
      wait_start("stp31", w);
      tick(1);
      do_done();
      exp_q.push_back(3'd4);
      wait_start("stp31_out", w);
      tick(1);
      do_done();
      exp_q.push_back(3'd0);
      wait_start("gc6", w);

`ifdef POLY_WATCHDOG_EN
      // Withhold done: watchdog trips after 16 WAIT cycles, then GET_COMMAND again
      tick(16);
      check_eq("wdog_before", 32'(wdog_err), 32'd0);
      tick(1);
      check_eq("wdog_set", 32'(wdog_err), 32'd1);
      exp_q.push_back(3'd0);
      wait_start("gc_after_wdog", w);
      check_eq("wdog_sticky", 32'(wdog_err), 32'd1);
`else
      check_eq("wdog_off", 32'(wdog_err), 32'd0);
`endif

      tick(2);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/poly_eval_invoke_fsm1.md
# poly_eval_invoke_fsm1

Level-1 invoke controller for the polynomial-evaluation actor. It sits directly upstream of `firing_state_FSM2`. Each cycle of operation it:
- tests FIFO populations and free space against the requirements of the pending firing mode;
- drives the selected mode and a start pulse into the level-2 FSM;
- waits for `done_fsm2`;
- computes the next mode from the decoded command.

It implements the CFDF enable/invoke sequence GET_COMMAND → {STP | EVP | EVB | RST} → OUTPUT → GET_COMMAND.

## Interface
Parameters:
- `word_size`, 16, datapath word width (kept for consistency with FSM2).
- `buffer_size`, 1024, FIFO depth; population ports are `PW = $clog2(buffer_size)+1` bits.
- `WDOG_CYCLES`, 4096, watchdog limit; used only when `POLY_WATCHDOG_EN` is defined.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `invoke` in 1 — run enable (level); 0 parks the controller in IDLE between firings.
- `pop_in_command` in PW — command FIFO population.
- `pop_in_data` in PW — data FIFO population.
- `free_out_result` in PW — result FIFO free space.
- `free_out_status` in PW — status FIFO free space.
- `instr_in` in 8 — decoded opcode from the get_command level-3 FSM.
- `arg2_in` in 5 — N (polynomial degree) from the get_command level-3 FSM.
- `error_in` in 2 — get_command error code.
- `done_fsm2` in 1 — level-2 completion pulse.
- `start_fsm2` out 1 — one-cycle start pulse.
- `next_mode_out` out 3 — mode to FSM2; MODE_NONE (3'b111) when not firing.
- `busy` out 1 — high from START through UPDATE inclusive.
- `wdog_err` out 1 — sticky watchdog flag; constant 0 when the feature is compiled out.

## Operation
Mode encodings:
- GET_COMMAND=0, STP=1, EVP=2, EVB=3, OUTPUT=4, RST=5, NONE=7.

Opcodes:
- STP=8'h01, EVP=8'h02, EVB=8'h03, RST=8'h04.

States: IDLE, CHECK, START, WAIT, UPDATE.
- **IDLE**: go to CHECK when `invoke`=1.
- **CHECK**: evaluate the enable condition for `mode_q`. If true → START. Else, if `invoke`=0 → IDLE; otherwise stay in CHECK.
- **START**: `start_fsm2`=1; `next_mode_out`=`mode_q`. → WAIT.
- **WAIT**: `next_mode_out`=`mode_q`. Go to UPDATE on `done_fsm2`=1.
- **UPDATE**: set `mode_q` from the next-mode rules below. → CHECK.

Enable conditions:
- GET_COMMAND: `pop_in_command` ≥ 1.
- STP: `pop_in_data` ≥ `arg_n_q`+1.
- EVP: `pop_in_data` ≥ 1.
- EVB: `pop_in_data` ≥ 2.
- RST: always true.
- OUTPUT: `free_out_result` ≥ 1 and `free_out_status` ≥ 1.

Next-mode rules:
- After GET_COMMAND, `instr_in`, `arg2_in` and `error_in` are captured into `instr_q`, `arg_n_q` and `err_q`.
- `err_q`≠0, or an opcode outside 1..4 → OUTPUT.
- Otherwise the mode is the one named by the opcode.
- After STP, EVP, EVB or RST → OUTPUT.
- After OUTPUT → GET_COMMAND.

Arithmetic: `arg_n_q`+1 is computed 6 bits wide, zero-extended to PW before the compare. N=31 therefore requires 32 tokens, with no wrap.

## Timing
Reset values:
- state=IDLE, `mode_q`=GET_COMMAND, `instr_q`=0, `arg_n_q`=0, `err_q`=0.
- Outputs: `start_fsm2`=0, `next_mode_out`=7, `busy`=0, `wdog_err`=0.

Latency and pacing:
- The enable condition true in CHECK at cycle t gives `start_fsm2`=1 at t+1.
- Minimum firing period is 4 cycles (CHECK, START, WAIT with immediate done, UPDATE).
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

Boundary conditions:
- **Mode hold**: `next_mode_out` holds constant from START until the cycle after `done_fsm2`.
- **Early done**: `done_fsm2` is sampled only in WAIT; a done in START is ignored.
- **`invoke` drop**: `invoke` dropping mid-firing does not abort the firing. It takes effect only in CHECK.
- **Back-pressure**: FIFO populations changing during WAIT have no effect.
- **Reset mid-firing**: reset in any state returns to IDLE with mode GET_COMMAND. A partially decoded command is discarded.

## Configuration
`POLY_WATCHDOG_EN`
- **Defined**: a 16-bit counter clears on START and increments in WAIT. When it reaches `WDOG_CYCLES`−1 without `done_fsm2`:
  - `wdog_err` sets and stays set until `rst`;
  - the controller goes to UPDATE with `mode_q` forced to GET_COMMAND.
- **Undefined**: there is no counter. WAIT waits indefinitely, and `wdog_err` is tied to 0.

## Structure
- Package `poly_eval_pkg` holds:
  - the mode encodings (incl. NONE);
  - the opcodes;
  - the state encodings;
  - a `PW` helper function.
- Sub-module `poly_enable_check` is purely combinational: inputs are mode, populations, free space and `arg_n_q`; output is `enabled`.
- The top level holds the state machine, the capture registers and the optional watchdog.

## Test plan
- Reset, then `invoke`=1 with `pop_in_command`=0 → stays in CHECK, `next_mode_out`=7. Set pop to 1 → `start_fsm2` pulses next cycle with mode 0.
- Command STP, N=3, with `pop_in_data`=3 → no start. Raise pop to 4 → STP start. Then done → OUTPUT mode 4, then GET_COMMAND mode 0.
- `error_in`=2'b01 on the GET_COMMAND done → next mode OUTPUT. With `free_out_status`=0 → held in CHECK until free space is 1.
- Opcode 8'h09 → OUTPUT. EVB with `pop_in_data`=1 → blocked; at 2 → fires with mode 3.
- `rst` asserted during WAIT of EVP → next cycle IDLE, mode 0, all outputs at reset values.
- With `POLY_WATCHDOG_EN` and `WDOG_CYCLES`=16, done withheld → `wdog_err`=1 after 16 WAIT cycles, then mode 0 is presented next.
